// File: rtl/bus_cmd_master.sv
// bus_cmd_master: command FIFO feeding one register-bus cycle at a time, with ack timeout.
// Define READBACK_VERIFY_EN to read back and compare every successful masked write.
module bus_cmd_master #(
    parameter int ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                  bus_clk,
    input  logic                  bus_reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [15:0]           cmd_mask,
    input  logic [15:0]           cmd_data,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [31:0]           bus_wr_data,
    output logic                  bus_we,
    output logic                  bus_re,
    input  logic [15:0]           bus_rd_data,
    input  logic                  bus_rd_ack,
    input  logic                  bus_wr_ack,
    output logic                  rsp_valid,
    output logic [15:0]           rsp_data,
    output logic                  rsp_err,
    output logic                  rsp_mismatch
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = 1 + ADDR_WIDTH + 32;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
`ifdef READBACK_VERIFY_EN
        VFY,
`endif
        RSP
    } state_t;

    state_t state, state_nxt;

    logic [EW-1:0]         fifo_mem [FIFO_DEPTH];
    logic [PW:0]           wptr, rptr;
    logic                  full, empty, push, pop;
    logic                  head_wr;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [15:0]           head_mask, head_data;
    logic [7:0]            tcnt;
    logic                  tout;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign empty     = (wptr == rptr);
    assign full      = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = (state == IDLE) && !empty;
    assign {head_wr, head_addr, head_mask, head_data} = fifo_mem[rptr[PW-1:0]];

    always_ff @(posedge bus_clk) begin
        if (push) begin
            fifo_mem[wptr[PW-1:0]] <= {cmd_wr, cmd_addr, cmd_mask, cmd_data};
        end
    end

    assign bus_we    = (state == WR);
`ifdef READBACK_VERIFY_EN
    assign bus_re    = (state == RD) || (state == VFY);
`else
    assign bus_re    = (state == RD);
`endif
    assign rsp_valid = (state == RSP);
    assign tout      = (tcnt == 8'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!empty) state_nxt = head_wr ? WR : RD;
            WR: begin
                if (bus_wr_ack) begin
`ifdef READBACK_VERIFY_EN
                    state_nxt = VFY;
`else
                    state_nxt = RSP;
`endif
                end else if (tout) begin
                    state_nxt = RSP;
                end
            end
            RD: if (bus_rd_ack || tout) state_nxt = RSP;
`ifdef READBACK_VERIFY_EN
            VFY: if (bus_rd_ack || tout) state_nxt = RSP;
`endif
            RSP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef READBACK_VERIFY_EN
    logic [15:0] cur_mask, cur_data;
`else
    assign rsp_mismatch = 1'b0;
`endif

    always_ff @(posedge bus_clk) begin
        if (bus_reset) begin
            state       <= IDLE;
            wptr        <= '0;
            rptr        <= '0;
            tcnt        <= '0;
            bus_addr    <= '0;
            bus_wr_data <= '0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
`ifdef READBACK_VERIFY_EN
            cur_mask     <= '0;
            cur_data     <= '0;
            rsp_mismatch <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (push) wptr <= wptr + (PW+1)'(1);
            if (pop)  rptr <= rptr + (PW+1)'(1);
            // Counts strobe cycles within one state; any state change restarts it
            tcnt <= ((state_nxt == state) && (bus_we || bus_re)) ? tcnt + 8'd1 : '0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        bus_addr    <= head_addr & ~ADDR_WIDTH'(3);
                        bus_wr_data <= head_wr ? {head_mask, head_data} : '0;
                        rsp_data    <= '0;
                        rsp_err     <= 1'b0;
`ifdef READBACK_VERIFY_EN
                        cur_mask     <= head_mask;
                        cur_data     <= head_data;
                        rsp_mismatch <= 1'b0;
`endif
                    end
                end
                WR: begin
                    if (bus_wr_ack) begin
`ifdef READBACK_VERIFY_EN
                        bus_wr_data <= '0;
`endif
                    end else if (tout) begin
                        rsp_err <= 1'b1;
                    end
                end
                RD: begin
                    if (bus_rd_ack)  rsp_data <= bus_rd_data;
                    else if (tout)   rsp_err  <= 1'b1;
                end
`ifdef READBACK_VERIFY_EN
                VFY: begin
                    if (bus_rd_ack) begin
                        rsp_data     <= bus_rd_data;
                        rsp_mismatch <= ((bus_rd_data ^ cur_data) & cur_mask) != '0;
                    end else if (tout) begin
                        rsp_err <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_cmd_master.sv
// tb_bus_cmd_master: directed commands against a bus_mask_reg-style slave model, responses scoreboarded.
// Define READBACK_VERIFY_EN to also cover write readback verification.
`timescale 1ns/1ps
module tb_bus_cmd_master;
    localparam int AW = 16;
    localparam int TO = 15;
`ifdef READBACK_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic          bus_clk = 1'b0;
    logic          bus_reset;
    logic          cmd_valid, cmd_ready, cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [15:0]   cmd_mask, cmd_data;
    logic [AW-1:0] bus_addr;
    logic [31:0]   bus_wr_data;
    logic          bus_we, bus_re;
    logic [15:0]   bus_rd_data;
    logic          bus_rd_ack, bus_wr_ack;
    logic          rsp_valid;
    logic [15:0]   rsp_data;
    logic          rsp_err, rsp_mismatch;

    bus_cmd_master #(.ADDR_WIDTH(AW), .FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
        .bus_clk(bus_clk), .bus_reset(bus_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_mask(cmd_mask), .cmd_data(cmd_data),
        .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_we(bus_we), .bus_re(bus_re),
        .bus_rd_data(bus_rd_data), .bus_rd_ack(bus_rd_ack), .bus_wr_ack(bus_wr_ack),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_mismatch(rsp_mismatch)
    );

    always #5 bus_clk = ~bus_clk;

    // Slave: one masked register at 0x10, ack delayed by ack_delay strobe cycles
    logic [15:0] slave_in, reg_out;
    int          ack_delay, cur_run;
    logic        force_wr_ack, force_rd_ack, slave_ok;

    assign slave_ok    = (bus_addr == 16'h0010) && (cur_run >= ack_delay);
    assign bus_wr_ack  = (bus_we && slave_ok) || force_wr_ack;
    assign bus_rd_ack  = (bus_re && slave_ok) || force_rd_ack;
    assign bus_rd_data = (bus_re && slave_ok) ? slave_in : 16'h0000;

    always @(posedge bus_clk) begin
        if (bus_reset) begin
            reg_out <= 16'hAAAA;
            cur_run <= 0;
        end else begin
            if (bus_we && slave_ok)
                reg_out <= (reg_out & ~bus_wr_data[31:16]) | (bus_wr_data[15:0] & bus_wr_data[31:16]);
            cur_run <= (bus_we || bus_re) ? cur_run + 1 : 0;
        end
    end

    typedef struct packed {
        logic [15:0] d;
        logic        e;
        logic        m;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_cmp = 0, n_bad = 0, n_rsp = 0, we_cnt = 0, re_cnt = 0;
    logic lsb_bad = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic rsp_t model(input logic wr, input logic [15:0] addr, mask, data);
        rsp_t r;
        logic mm;
        r  = '0;
        mm = ((slave_in ^ data) & mask) != 16'h0;
        if ((addr & 16'hFFFC) != 16'h0010 || ack_delay >= TO) begin
            r.e = 1'b1;
        end else begin
            r.d = (wr && !VERIFY) ? 16'h0000 : slave_in;
            r.m = wr && VERIFY && mm;
        end
        return r;
    endfunction

    always @(negedge bus_clk) begin
        if (bus_we) we_cnt++;
        if (bus_re) re_cnt++;
        if ((bus_we || bus_re) && bus_addr[1:0] != 2'b00) lsb_bad = 1'b1;
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", rsp_valid, 1'b0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                n_rsp++;
                chk("rsp_data", rsp_data, e.d);
                chk("rsp_err", rsp_err, e.e);
                chk("rsp_mismatch", rsp_mismatch, e.m);
            end
        end
    end

    task automatic push(input logic wr, input logic [15:0] addr, mask, data, input bit expect_rsp);
        int k = 0;
        while (!cmd_ready && k < 200) begin
            @(negedge bus_clk);
            k++;
        end
        if (!cmd_ready) begin
            chk("push_ready_timeout", cmd_ready, 1'b1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_mask  = mask;
        cmd_data  = data;
        if (expect_rsp) exp_q.push_back(model(wr, addr, mask, data));
        @(posedge bus_clk);
        @(negedge bus_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge bus_clk);
            k++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        repeat (2) @(negedge bus_clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w0, r0, n0;
        bus_reset = 1'b1;
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_mask = '0; cmd_data = '0;
        slave_in = 16'hBEEF; ack_delay = 0; force_wr_ack = 1'b0; force_rd_ack = 1'b0;
        repeat (3) @(posedge bus_clk);
        @(negedge bus_clk);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_bus_we", bus_we, 1'b0);
        chk("rst_bus_re", bus_re, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_bus_addr", bus_addr, 16'h0);
        chk("rst_bus_wr_data", bus_wr_data, 32'h0);
        chk("rst_rsp", {rsp_data, rsp_err, rsp_mismatch}, 18'h0);
        bus_reset = 1'b0;
        @(negedge bus_clk);

        // Single masked write: exact strobe timing and register effect
        w0 = we_cnt;
        push(1'b1, 16'h0010, 16'h00FF, 16'h1234, 1'b1);
        chk("t1_we_before", bus_we, 1'b0);
        @(negedge bus_clk);
        chk("t1_we_on", bus_we, 1'b1);
        chk("t1_wr_data", bus_wr_data, 32'h00FF1234);
        chk("t1_addr", bus_addr, 16'h0010);
        @(negedge bus_clk);
        chk("t1_we_off", bus_we, 1'b0);
`ifdef READBACK_VERIFY_EN
        chk("t1_vfy_re", bus_re, 1'b1);
        chk("t1_vfy_wr_data", bus_wr_data, 32'h0);
        @(negedge bus_clk);
`endif
        chk("t1_rsp_valid", rsp_valid, 1'b1);
        drain(50);
        chk("t1_we_cycles", we_cnt - w0, 1);
        chk("t1_reg_out", reg_out, 16'hAA34);

        // Reads, including an unaligned address that must land on 0x10
        r0 = re_cnt;
        push(1'b0, 16'h0010, 16'h0, 16'h0, 1'b1);
        push(1'b0, 16'h0013, 16'h0, 16'h0, 1'b1);
        drain(50);
        chk("t2_re_cycles", re_cnt - r0, 2);

        // Unmapped write times out after TIMEOUT strobe cycles
        w0 = we_cnt;
        push(1'b1, 16'h07FC, 16'hFFFF, 16'h5555, 1'b1);
        drain(100);
        chk("t3_we_cycles", we_cnt - w0, TO);
        chk("t3_reg_out", reg_out, 16'hAA34);

        // Wrong-type ack during a read is ignored
        force_wr_ack = 1'b1;
        r0 = re_cnt;
        push(1'b0, 16'h07FC, 16'h0, 16'h0, 1'b1);
        drain(100);
        chk("t3_wrong_ack_re_cycles", re_cnt - r0, TO);

        // Acks with no command outstanding are ignored
        force_rd_ack = 1'b1;
        n0 = n_rsp; w0 = we_cnt; r0 = re_cnt;
        repeat (6) @(negedge bus_clk);
        force_wr_ack = 1'b0;
        force_rd_ack = 1'b0;
        chk("idle_ack_no_rsp", n_rsp - n0, 0);
        chk("idle_ack_no_strobe", (we_cnt - w0) + (re_cnt - r0), 0);

        // Ack in the final permitted cycle wins; one cycle later is a timeout
        ack_delay = TO - 1;
        r0 = re_cnt;
        push(1'b0, 16'h0010, 16'h0, 16'h0, 1'b1);
        drain(100);
        chk("last_cycle_ack_re_cycles", re_cnt - r0, TO);
        ack_delay = TO;
        r0 = re_cnt;
        push(1'b0, 16'h0010, 16'h0, 16'h0, 1'b1);
        drain(100);
        chk("late_ack_re_cycles", re_cnt - r0, TO);
        ack_delay = 0;

        // Stall the bus, fill the FIFO behind it, then overflow by one
        w0 = we_cnt;
        push(1'b1, 16'h07FC, 16'h0001, 16'h0001, 1'b1);
        push(1'b1, 16'h0010, 16'hFFFF, 16'h1111, 1'b1);
        push(1'b0, 16'h07FC, 16'h0, 16'h0, 1'b1);
        push(1'b0, 16'h0010, 16'h0, 16'h0, 1'b1);
        push(1'b1, 16'h0010, 16'h0000, 16'hFFFF, 1'b1);
        chk("t4_full_ready", cmd_ready, 1'b0);
        push(1'b0, 16'h0010, 16'h0, 16'h0, 1'b1);
        drain(400);
        chk("t4_we_cycles", we_cnt - w0, TO + 2);
        chk("t4_reg_out", reg_out, 16'h1111);

        // Reset during a write strobe drops it and flushes the queued command
        n0 = n_rsp; r0 = re_cnt;
        push(1'b1, 16'h07FC, 16'hFFFF, 16'h0000, 1'b0);
        push(1'b0, 16'h0010, 16'h0, 16'h0, 1'b0);
        for (int k = 0; k < 20 && !bus_we; k++) @(negedge bus_clk);
        chk("t5_strobe_seen", bus_we, 1'b1);
        bus_reset = 1'b1;
        @(posedge bus_clk);
        #1;
        chk("t5_we_dropped", bus_we, 1'b0);
        chk("t5_re_low", bus_re, 1'b0);
        chk("t5_cmd_ready", cmd_ready, 1'b1);
        chk("t5_rsp_valid", rsp_valid, 1'b0);
        @(negedge bus_clk);
        bus_reset = 1'b0;
        repeat (20) @(negedge bus_clk);
        chk("t5_no_rsp", n_rsp - n0, 0);
        chk("t5_flushed_no_read", re_cnt - r0, 0);

`ifdef READBACK_VERIFY_EN
        // Readback verify: mismatching and matching readback
        slave_in = 16'h0000;
        push(1'b1, 16'h0010, 16'h000F, 16'h0005, 1'b1);
        drain(100);
        slave_in = 16'h0005;
        push(1'b1, 16'h0010, 16'h000F, 16'h0005, 1'b1);
        drain(100);
`endif

        chk("addr_lsbs_zero", lsb_bad, 1'b0);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
